vga_grid_pattern: RTL and testbench



---
 rtl/vga_grid_pattern.sv | 175 +++++++++++++++++
 tb/tb_vga_grid_pattern.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/vga_grid_pattern.sv
// rtl/vga_grid_pattern.sv - registered VGA test pattern: grid, scrolling grid, colour bars, flat field
module vga_grid_pattern #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int GRID       = 10,
    parameter int COLOR_W    = 8,
    parameter int SCROLL_DIV = 15
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [9:0]         next_x,
    input  logic [9:0]         next_y,
    input  logic               blank_n,
    input  logic [1:0]         mode,
    input  logic [COLOR_W-1:0] intensity,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               frame_tick
);

    localparam logic [5:0] GRID_MAX = 6'(GRID - 1);
    localparam logic [7:0] DIV_MAX  = 8'(SCROLL_DIV - 1);
    localparam logic [9:0] X_LAST   = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_ACTIVE - 1);

    logic [9:0]         x_prev_q, x_prev_d, y_prev_q, y_prev_d;
    logic [5:0]         x_phase_q, x_phase_d, y_phase_q, y_phase_d;
    logic [1:0]         x_idx_q, x_idx_d, y_idx_q, y_idx_d;
    logic [1:0]         mode_q, mode_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic [5:0]         scroll_q, scroll_d;
    logic               started_q, started_d;
    logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic               frame_tick_q, frame_tick_d;

    logic               frame_start;
    logic               lit_r, lit_g, lit_b;
    logic [2:0]         bar;

    // Frame bookkeeping: detect frame start, latch mode, advance the scroll offset
    always_comb begin
        frame_start  = (next_x == 10'd0) && (next_y == 10'd0) && (y_prev_q != 10'd0);
        frame_tick_d = frame_start;
        mode_d       = frame_start ? mode : mode_q;
        started_d    = started_q | frame_start;
        frame_cnt_d  = frame_cnt_q;
        scroll_d     = scroll_q;
        if (frame_start) begin
            if (frame_cnt_q >= DIV_MAX) begin
                frame_cnt_d = 8'd0;
                scroll_d    = (scroll_q >= GRID_MAX) ? 6'd0 : scroll_q + 6'd1;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
        x_prev_d = next_x;
        y_prev_d = next_y;
    end

    // Phase/index counters for the pixel currently on next_x/next_y; wrap with >= so bad states self-heal
    always_comb begin
        x_phase_d = x_phase_q;
        x_idx_d   = x_idx_q;
        if (next_x == 10'd0) begin
            x_phase_d = (mode_d == 2'd1) ? scroll_d : 6'd0;
            x_idx_d   = 2'd0;
        end else if (next_x != x_prev_q) begin
            if (x_phase_q >= GRID_MAX) begin
                x_phase_d = 6'd0;
                x_idx_d   = (x_idx_q >= 2'd2) ? 2'd0 : x_idx_q + 2'd1;
            end else begin
                x_phase_d = x_phase_q + 6'd1;
            end
        end
        y_phase_d = y_phase_q;
        y_idx_d   = y_idx_q;
        if (next_y == 10'd0) begin
            y_phase_d = 6'd0;
            y_idx_d   = 2'd0;
        end else if (next_y != y_prev_q) begin
            if (y_phase_q >= GRID_MAX) begin
                y_phase_d = 6'd0;
                y_idx_d   = (y_idx_q >= 2'd2) ? 2'd0 : y_idx_q + 2'd1;
            end else begin
                y_phase_d = y_phase_q + 6'd1;
            end
        end
    end

    // Pattern select; colour index 0=green, 1=red, 2=blue; blanking and pre-first-frame force black
    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (next_x >= 10'(k * H_ACTIVE / 8)) bar = 3'(k);
        end
        lit_r = 1'b0;
        lit_g = 1'b0;
        lit_b = 1'b0;
        case (mode_d)
            2'd0, 2'd1: begin
                if (next_x == X_LAST || next_y == Y_LAST) begin
                    lit_b = 1'b1;
                end else if (x_phase_d == 6'd0) begin
                    lit_g = (x_idx_d == 2'd0);
                    lit_r = (x_idx_d == 2'd1);
                    lit_b = (x_idx_d == 2'd2);
                end else if (y_phase_d == 6'd0) begin
                    lit_g = (y_idx_d == 2'd0);
                    lit_r = (y_idx_d == 2'd1);
                    lit_b = (y_idx_d == 2'd2);
                end
            end
            2'd2: begin
                lit_r = bar[2];
                lit_g = bar[1];
                lit_b = bar[0];
            end
            default: begin
                lit_r = 1'b1;
                lit_g = 1'b1;
                lit_b = 1'b1;
            end
        endcase
        if (!blank_n || !started_d) begin
            lit_r = 1'b0;
            lit_g = 1'b0;
            lit_b = 1'b0;
        end
        red_d   = lit_r ? intensity : '0;
        green_d = lit_g ? intensity : '0;
        blue_d  = lit_b ? intensity : '0;
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            x_prev_q     <= 10'd0;
            y_prev_q     <= 10'd0;
            x_phase_q    <= 6'd0;
            y_phase_q    <= 6'd0;
            x_idx_q      <= 2'd0;
            y_idx_q      <= 2'd0;
            mode_q       <= 2'd0;
            frame_cnt_q  <= 8'd0;
            scroll_q     <= 6'd0;
            started_q    <= 1'b0;
            red_q        <= '0;
            green_q      <= '0;
            blue_q       <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            x_prev_q     <= x_prev_d;
            y_prev_q     <= y_prev_d;
            x_phase_q    <= x_phase_d;
            y_phase_q    <= y_phase_d;
            x_idx_q      <= x_idx_d;
            y_idx_q      <= y_idx_d;
            mode_q       <= mode_d;
            frame_cnt_q  <= frame_cnt_d;
            scroll_q     <= scroll_d;
            started_q    <= started_d;
            red_q        <= red_d;
            green_q      <= green_d;
            blue_q       <= blue_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign red        = red_q;
    assign green      = green_q;
    assign blue       = blue_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_grid_pattern.sv
// tb/tb_vga_grid_pattern.sv - randomized scoreboard bench for vga_grid_pattern
module tb_vga_grid_pattern;

    localparam int H    = 48;
    localparam int V    = 24;
    localparam int GR   = 10;
    localparam int CW   = 8;
    localparam int SDIV = 2;
    localparam int HT   = H + 4;
    localparam int VT   = V + 2;
    localparam int NCYC = 26 * HT * VT;
    localparam int RST_AT = 4000;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [9:0]    next_x = '0;
    logic [9:0]    next_y = '0;
    logic          blank_n = 1'b0;
    logic [1:0]    mode = '0;
    logic [CW-1:0] intensity = '0;
    logic [CW-1:0] red, green, blue;
    logic          frame_tick;

    vga_grid_pattern #(
        .H_ACTIVE(H), .V_ACTIVE(V), .GRID(GR), .COLOR_W(CW), .SCROLL_DIV(SDIV)
    ) dut (
        .clock(clock), .reset_n(reset_n), .next_x(next_x), .next_y(next_y),
        .blank_n(blank_n), .mode(mode), .intensity(intensity),
        .red(red), .green(green), .blue(blue), .frame_tick(frame_tick)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            x;
        int            y;
        logic [CW-1:0] r;
        logic [CW-1:0] g;
        logic [CW-1:0] b;
        logic          t;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_ticks = 0;
    int   act_ticks = 0;

    // reference model state
    int   m_mode = 0;
    int   m_frames = 0;
    int   m_started = 0;
    int   m_prev_y = 0;

    task automatic model_step(input int x, input int y, input int bl, input int md,
                              input logic [CW-1:0] inten, input int rstn);
        exp_t e;
        int   scroll, s, ch, bar;
        logic lr, lg, lb;
        e.x = x; e.y = y; e.r = '0; e.g = '0; e.b = '0; e.t = 1'b0;
        if (rstn == 0) begin
            m_mode = 0; m_frames = 0; m_started = 0; m_prev_y = 0;
        end else begin
            if (x == 0 && y == 0 && m_prev_y != 0) begin
                e.t = 1'b1;
                exp_ticks++;
                m_frames++;
                m_mode = md;
                m_started = 1;
            end
            m_prev_y = y;
            lr = 1'b0; lg = 1'b0; lb = 1'b0;
            scroll = (m_frames / SDIV) % GR;
            if (m_mode <= 1) begin
                s = (m_mode == 1) ? scroll : 0;
                ch = -1;
                if (x == H - 1 || y == V - 1) ch = 2;
                else if ((s + x) % GR == 0) ch = ((s + x) / GR) % 3;
                else if (y % GR == 0) ch = (y / GR) % 3;
                lg = (ch == 0); lr = (ch == 1); lb = (ch == 2);
            end else if (m_mode == 2) begin
                bar = (x * 8) / H;
                lr = bar[2]; lg = bar[1]; lb = bar[0];
            end else begin
                lr = 1'b1; lg = 1'b1; lb = 1'b1;
            end
            if (bl != 0 && m_started != 0) begin
                e.r = lr ? inten : '0;
                e.g = lg ? inten : '0;
                e.b = lb ? inten : '0;
            end
        end
        exp_q.push_back(e);
    endtask

    // monitor: one registered output per clock, compared against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (frame_tick === 1'b1) act_ticks++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (red !== e.r || green !== e.g || blue !== e.b || frame_tick !== e.t) begin
                    miscompares++;
                    $display("FAIL pixel (%0d,%0d): got r=%h g=%h b=%h tick=%b, want r=%h g=%h b=%h tick=%b",
                             e.x, e.y, red, green, blue, frame_tick, e.r, e.g, e.b, e.t);
                end
            end
        end
    end

    // driver: raster like vga_driver, random mode/intensity/blanking, resets at start and mid-frame
    initial begin
        int cx, cy, act, bl, md, rstn;
        logic [CW-1:0] inten;
        cx = 0;
        cy = VT - 3;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clock);
            rstn = (cyc < 5 || (cyc >= RST_AT && cyc < RST_AT + 5)) ? 0 : 1;
            act = (cx < H && cy < V) ? 1 : 0;
            bl = (act != 0 && $urandom_range(0, 7) != 0) ? 1 : 0;
            md = $urandom_range(0, 3);
            inten = CW'($urandom);
            reset_n = rstn[0];
            next_x = 10'(cx);
            next_y = 10'(cy);
            blank_n = bl[0];
            mode = 2'(md);
            intensity = inten;
            model_step(cx, cy, bl, md, inten, rstn);
            cx++;
            if (cx == HT) begin
                cx = 0;
                cy = (cy == VT - 1) ? 0 : cy + 1;
            end
        end
        repeat (3) @(negedge clock);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        vectors++;
        if (act_ticks != exp_ticks) begin
            miscompares++;
            $display("FAIL tick_count: got %0d, want %0d", act_ticks, exp_ticks);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
